// File: rtl/debug_run_controller.sv
// debug_run_controller: run control for a core behind a registered clock
// enable. Supports free run, N-instruction stepping, address breakpoints and
// external halt requests. Captures the last committed retirement and muxes a
// value out for the seven-segment display.
module debug_run_controller #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_BP         = 2,
    parameter int STEP_WIDTH     = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   i_mode,
    input  logic [STEP_WIDTH-1:0]        i_step_count,
    input  logic                         i_resume,
    input  logic                         i_halt_req,
    input  logic [NUM_BP-1:0]            i_bp_en,
    input  logic [NUM_BP*ADDR_WIDTH-1:0] i_bp_addr,
    input  logic                         i_retire_en,
    input  logic [ADDR_WIDTH-1:0]        i_retire_iaddr,
    input  logic [DATA_WIDTH-1:0]        i_retire_data,
    input  logic [REG_ADDR_WIDTH-1:0]    i_retire_rdest,
    input  logic [1:0]                   i_disp_sel,
    output logic                         o_core_en,
    output logic                         o_halted,
    output logic [1:0]                   o_halt_cause,
    output logic [NUM_BP-1:0]            o_bp_hit,
    output logic [31:0]                  o_retire_count,
    output logic [DATA_WIDTH-1:0]        o_disp_data
);

    localparam logic ST_RUN  = 1'b0;
    localparam logic ST_HALT = 1'b1;

    localparam logic [1:0] CAUSE_NONE = 2'd0;
    localparam logic [1:0] CAUSE_STEP = 2'd1;
    localparam logic [1:0] CAUSE_BP   = 2'd2;
    localparam logic [1:0] CAUSE_EXT  = 2'd3;

    logic                      state, state_nxt;
    logic [1:0]                cause_nxt;
    logic [NUM_BP-1:0]         bp_hit_nxt, bp_match;
    logic [STEP_WIDTH-1:0]     rem, rem_cur, step_eff;
    logic                      rem_pending;
    logic                      commit, halt_bp, halt_step;
    logic [DATA_WIDTH-1:0]     cap_data;
    logic [ADDR_WIDTH-1:0]     cap_iaddr;
    logic [REG_ADDR_WIDTH-1:0] cap_rdest;

    // A step count of zero behaves as one.
    assign step_eff = (i_step_count == '0) ? STEP_WIDTH'(1) : i_step_count;

    // After reset rem tracks i_step_count until the first retire or resume,
    // so the reset branch only ever loads constants.
    assign rem_cur  = rem_pending ? step_eff : rem;

    // Only retires seen while the core is enabled have any effect.
    assign commit   = i_retire_en & o_core_en;
    assign o_halted = (state == ST_HALT);

    // Per-breakpoint address match against the retiring instruction.
    always_comb begin
        bp_match = '0;
        for (int k = 0; k < NUM_BP; k++)
            bp_match[k] = i_bp_en[k] &&
                          (i_bp_addr[k*ADDR_WIDTH +: ADDR_WIDTH] == i_retire_iaddr);
    end

    assign halt_bp   = commit & i_mode[1] & (|bp_match);
    assign halt_step = commit & i_mode[0] & (rem_cur == STEP_WIDTH'(1));

    // Next state and halt cause; breakpoint beats step beats external.
    always_comb begin
        state_nxt  = state;
        cause_nxt  = o_halt_cause;
        bp_hit_nxt = o_bp_hit;
        if (state == ST_RUN) begin
            if (halt_bp) begin
                state_nxt  = ST_HALT;
                cause_nxt  = CAUSE_BP;
                bp_hit_nxt = bp_match;
            end else if (halt_step) begin
                state_nxt  = ST_HALT;
                cause_nxt  = CAUSE_STEP;
                bp_hit_nxt = '0;
            end else if (i_halt_req) begin
                state_nxt  = ST_HALT;
                cause_nxt  = CAUSE_EXT;
                bp_hit_nxt = '0;
            end
        end else if (i_resume) begin
            state_nxt  = ST_RUN;
            cause_nxt  = CAUSE_NONE;
            bp_hit_nxt = '0;
        end
    end

    // State, cause and core enable; the enable is a registered decode of
    // the next state so the core sees a glitch-free stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_RUN;
            o_core_en    <= 1'b1;
            o_halt_cause <= CAUSE_NONE;
            o_bp_hit     <= '0;
        end else begin
            state        <= state_nxt;
            o_core_en    <= (state_nxt == ST_RUN);
            o_halt_cause <= cause_nxt;
            o_bp_hit     <= bp_hit_nxt;
        end
    end

    // Step counter: reload on resume, saturating decrement per retire.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem         <= '0;
            rem_pending <= 1'b1;
        end else if ((state == ST_HALT) && i_resume) begin
            rem         <= step_eff;
            rem_pending <= 1'b0;
        end else if (commit) begin
            rem         <= (rem_cur == '0) ? '0 : rem_cur - STEP_WIDTH'(1);
            rem_pending <= 1'b0;
        end
    end

    // Capture and count every committed retire, including the halting one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_data       <= '0;
            cap_iaddr      <= '0;
            cap_rdest      <= '0;
            o_retire_count <= '0;
        end else if (commit) begin
            cap_data       <= i_retire_data;
            cap_iaddr      <= i_retire_iaddr;
            cap_rdest      <= i_retire_rdest;
            o_retire_count <= o_retire_count + 32'd1;
        end
    end

    // Display source mux; casts zero-extend or truncate to DATA_WIDTH.
    always_comb begin
        o_disp_data = '0;
        case (i_disp_sel)
            2'd0:    o_disp_data = cap_data;
            2'd1:    o_disp_data = DATA_WIDTH'(cap_iaddr);
            2'd2:    o_disp_data = DATA_WIDTH'(o_retire_count);
            default: o_disp_data = DATA_WIDTH'({cap_rdest, o_halt_cause});
        endcase
    end

endmodule

// File: doc/debug_run_controller.md
# debug_run_controller

Run-control and observation block that replaces the fixed "halt after every retire, resume on key" logic in board-level synthesis tops with a parametrised controller. It sits between the reorder buffer's retire port and the core's clock-enable, and supports free-run, N-instruction stepping, address breakpoints and external halt requests. It captures the last committed retirement and presents a selectable value for the seven-segment display. The core is stalled through a registered enable, never a gated clock.

## Interface
- DATA_WIDTH, 32, retire data and display width
- ADDR_WIDTH, 32, instruction address width
- REG_ADDR_WIDTH, 5, destination register index width
- NUM_BP, 2, number of address breakpoints (1..8)
- STEP_WIDTH, 8, step counter width

- clk  in  1  system clock; the only clock
- rst  in  1  asynchronous, active-high reset
- i_mode  in  2  bit0 step enable, bit1 breakpoint enable; 00 = free run
- i_step_count  in  STEP_WIDTH  retirements per step; 0 treated as 1
- i_resume  in  1  single-cycle synchronous pulse (already edge-detected)
- i_halt_req  in  1  external halt request, level
- i_bp_en  in  NUM_BP  per-breakpoint enable
- i_bp_addr  in  NUM_BP*ADDR_WIDTH  breakpoint addresses, bp k at [k*ADDR_WIDTH +: ADDR_WIDTH]
- i_retire_en  in  1  ROB retire valid
- i_retire_iaddr  in  ADDR_WIDTH  retiring instruction address
- i_retire_data  in  DATA_WIDTH  retiring result
- i_retire_rdest  in  REG_ADDR_WIDTH  retiring destination register
- i_disp_sel  in  2  display source select
- o_core_en  out  1  core advance enable, registered
- o_halted  out  1  state == HALT
- o_halt_cause  out  2  0 none, 1 step, 2 breakpoint, 3 external
- o_bp_hit  out  NUM_BP  breakpoints matched by the halting retire
- o_retire_count  out  32  committed retirements, wraps
- o_disp_data  out  DATA_WIDTH  selected display value

## Operation
- States: RUN (o_core_en=1), HALT (o_core_en=0). o_core_en is a registered decode of next state.
- Committed retire = i_retire_en & o_core_en. Retire strobes while o_core_en=0 are ignored entirely: no counter, capture or halt effect.
- Step counter rem: loaded with max(i_step_count,1) at reset and on every accepted resume; decremented on each committed retire, saturating at 0.
- Halt conditions in RUN, evaluated on a committed retire:
  - bp: i_mode[1] and any k with i_bp_en[k] and i_bp_addr[k]==i_retire_iaddr
  - step: i_mode[0] and rem==1
- Halt conditions in RUN, evaluated without a retire: ext, i_halt_req=1.
- Any condition -> HALT. Cause priority: bp(2) > step(1) > ext(3). o_bp_hit latches the per-k match vector on a bp halt, else is 0.
- HALT: i_resume -> RUN. Resume clears o_halt_cause and o_bp_hit and reloads rem. i_halt_req is ignored in HALT; resume wins when both are asserted. i_resume in RUN has no effect.
- Capture registers (data, iaddr, rdest) update on every committed retire, including the halting one.
- o_retire_count increments on every committed retire, modulo 2^32.
- o_disp_data by i_disp_sel:
  - 0: captured data
  - 1: captured iaddr, zero-extended or truncated to DATA_WIDTH
  - 2: o_retire_count, truncated or zero-extended
  - 3: {zeros, rdest, halt_cause}
- Mode changes take effect immediately. rem is not reloaded on a mode change.

## Timing
- Reset (async, immediate): state RUN, o_core_en=1, o_halted=0, o_halt_cause=0, o_bp_hit=0, o_retire_count=0, captures=0, rem=max(i_step_count,1), o_disp_data reflects zeroed registers.
- Halt latency: a committed retire in cycle t meeting a condition gives o_core_en=0 and o_halted=1 in cycle t+1. The retire in cycle t is committed; nothing after it is.
- External halt: i_halt_req high in cycle t gives HALT in t+1. A retire committed in cycle t still counts.
- Resume: pulse in cycle t gives o_core_en=1 in cycle t+1.
- o_disp_data: combinational from registers and i_disp_sel; reflects a capture one cycle after the retire.
- Reset asserted mid-HALT or mid-step aborts the step and returns to RUN immediately.

## Test plan
- Free run: reset, mode 00, 5 consecutive retires -> o_core_en stays 1, o_retire_count=5, o_halted=0.
- Step: mode 01, step_count=3, continuous retires -> halt cycle after 3rd retire, cause 1, count=3. Held retire_en while halted leaves count=3. Resume -> o_core_en=1 next cycle, halts again at count=6.
- Breakpoint: mode 10, bp0=0x40 enabled, retire 0x3C then 0x40 -> HALT after 0x40, cause 2, o_bp_hit=01. disp_sel=1 -> 0x40; disp_sel=0 -> last retire data.
- Priority: mode 11, step_count=1, retire at bp1 address -> cause 2, o_bp_hit=10. step_count=0 behaves as 1.
- External: i_halt_req in RUN -> HALT next cycle, cause 3. In HALT, resume and halt_req in the same cycle -> RUN next cycle, cause 0.
- Reset mid-HALT after 7 retires: assert rst -> o_core_en=1, count 0, cause 0 without a clock edge. Wraparound: preload via 2^32 retires (forced) -> count 0.
